fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register. Sits directly upstream of the controller.
//   - Owns the PC and the instruction-memory request handshake (at most one request outstanding).
//   - Delivers instr_decode; its opcode/funct slices drive the controller.
//   - Applies the decode-stage redirect: branch / jump / jr.
// PARAMETERS
//   RESET_PC  32'h0040_0000  PC loaded on reset
// PORTS
//   clk                 in   1   clock, rising edge
//   reset               in   1   asynchronous, active-high reset
//   stall_decode        in   1   hazard unit: hold IF/ID contents
//   pc_source_decode    in   2   [0]=branch taken, [1]=jump (from controller)
//   jump_pc_decode      in   1   jr: redirect to register target
//   branch_target_decode in  32  branch target address
//   jump_target_decode  in   32  j/jal target address
//   jr_target_decode    in   32  register (jr) target address
//   imem_req            out  1   request valid
//   imem_addr           out  32  request address (= pc_fetch)
//   imem_ready          in   1   memory accepts request this cycle
//   imem_rvalid         in   1   response valid (>=1 cycle after accept)
//   imem_rdata          in   32  response instruction
//   instr_decode        out  32  IF/ID instruction (32'h0 = bubble/nop)
//   pc_plus4_decode     out  32  address of instr_decode + 4
//   valid_decode        out  1   IF/ID holds a real instruction
//   opcode_decode       out  6   instr_decode[31:26]
//   funct_decode        out  6   instr_decode[5:0]
// BEHAVIOUR
//   Reset (async, immediate)
//     - pc_fetch=RESET_PC, state=RUN, buf_valid=0
//     - instr_decode=0, pc_plus4_decode=0, valid_decode=0
//     - imem_req may assert in the first cycle after reset deasserts.
//   State machine
//     - RUN:  nothing outstanding
//     - WAIT: one request outstanding, response is kept
//     - DROP: one request outstanding, response is discarded
//     - RUN  -> WAIT on accept (imem_req & imem_ready)
//     - WAIT/DROP -> RUN on imem_rvalid, or -> WAIT if a new request is accepted in the same cycle
//     - Any accept in the same cycle as a redirect -> DROP
//     - WAIT -> DROP on a redirect
//     - imem_rvalid in RUN is ignored.
//   Request issue
//     - imem_req=1 when (state==RUN, or imem_rvalid this cycle) and no buffered instruction
//       would be left unconsumed, i.e. !(buf_valid & stall_decode) and !(stall_decode & response arriving).
//     - imem_addr is combinationally pc_fetch.
//     - imem_req and imem_addr hold stable while imem_ready=0.
//     - The PC of the accepted request is saved as req_pc.
//   PC update
//     - redirect = valid_decode & !stall_decode & (jump_pc_decode | |pc_source_decode)
//     - Target priority: jump_pc_decode -> jr_target; else pc_source_decode[1] -> jump_target;
//       else pc_source_decode[0] -> branch_target.
//     - Redirect loads pc_fetch=target; this overrides the +4 of a same-cycle accept.
//     - Otherwise an accept sets pc_fetch+=4 (32-bit wrap, no trap).
//   IF/ID load when !stall_decode, first match wins:
//     1. redirect -> bubble (instr 0, valid 0); buf_valid cleared
//     2. buf_valid -> buffer contents; buf_valid cleared
//     3. imem_rvalid in WAIT -> {imem_rdata, req_pc+4}, valid 1
//     4. else bubble
//   When stall_decode:
//     - IF/ID holds.
//     - imem_rvalid in WAIT is written to a 1-entry skid buffer with buf_pc=req_pc.
//   Latency and bubbles
//     - Zero-wait memory (ready=1, rvalid one cycle after accept): 1 instruction per cycle.
//     - First instruction reaches IF/ID 2 cycles after reset release.
//     - Redirect costs exactly 2 bubble cycles.
//   No instruction is ever lost or duplicated across stalls, redirects or wait states.
// TESTING
//   1. RESET_PC=0x0040_0000, zero-wait memory returning addr-as-data.
//      -> imem_addr 0x400000, 0x400004, ...; instr_decode follows one per cycle, pc_plus4 = instr+4.
//   2. Decode branch (pc_source=01, target 0x0040_0100) at cycle N.
//      -> valid_decode=0 at N+1 and N+2; the stale response is dropped;
//         instr_decode=0x0040_0100 at N+3.
//   3. stall_decode high for 3 cycles mid-stream.
//      -> instr_decode held; one response buffered; imem_req low;
//      -> after release, the buffered instruction appears, then its successor, with no gap or repeat.
//   4. imem_ready=0 for 2 cycles.
//      -> imem_req=1 with imem_addr constant; pc_fetch does not advance; no spurious valid_decode.
//   5. jump_pc_decode=1 with pc_source=10 (jr target 0x0040_0200, jump target 0x0040_0300).
//      -> fetch restarts at 0x0040_0200.
//   6. Assert reset while in WAIT, then deliver the stale imem_rvalid after release.
//      -> outputs zero immediately; stale data ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, keeps at most one
// instruction-memory request in flight, and applies decode-stage branch/jump/jr redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_decode,
    input  logic [1:0]  pc_source_decode,
    input  logic        jump_pc_decode,
    input  logic [31:0] branch_target_decode,
    input  logic [31:0] jump_target_decode,
    input  logic [31:0] jr_target_decode,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_decode,
    output logic [31:0] pc_plus4_decode,
    output logic        valid_decode,
    output logic [5:0]  opcode_decode,
    output logic [5:0]  funct_decode
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_fetch;
    logic [XLEN-1:0] req_pc;
    logic            buf_valid;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;

    logic            resp;
    logic            keep;
    logic            accept;
    logic            redirect;
    logic [XLEN-1:0] target;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Handshake, redirect decode and next-state logic.
    always_comb begin
        state_next = state;
        resp       = imem_rvalid & (state != ST_RUN);
        keep       = imem_rvalid & (state == ST_WAIT);
        // Never issue if the returning/buffered instruction could not drain into IF/ID.
        imem_req   = !reset
                   & ((state == ST_RUN) | resp)
                   & !(buf_valid & stall_decode)
                   & !(stall_decode & keep);
        accept     = imem_req & imem_ready;
        redirect   = valid_decode & !stall_decode
                   & (jump_pc_decode | (|pc_source_decode));
        target     = branch_target_decode;
        if (jump_pc_decode) begin
            target = jr_target_decode;
        end else if (pc_source_decode[1]) begin
            target = jump_target_decode;
        end

        if (accept) begin
            state_next = redirect ? ST_DROP : ST_WAIT;
        end else if (resp) begin
            state_next = ST_RUN;
        end else if ((state == ST_WAIT) && redirect) begin
            state_next = ST_DROP;
        end
    end

    assign imem_addr     = pc_fetch;
    assign opcode_decode = instr_decode[31:26];
    assign funct_decode  = instr_decode[5:0];

    // PC, outstanding-request PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_fetch        <= RESET_PC;
            req_pc          <= '0;
            buf_valid       <= 1'b0;
            buf_instr       <= '0;
            buf_pc          <= '0;
            instr_decode    <= '0;
            pc_plus4_decode <= '0;
            valid_decode    <= 1'b0;
        end else begin
            if (redirect) begin
                pc_fetch <= target;
            end else if (accept) begin
                pc_fetch <= pc_fetch + INSTR_BYTES;
            end

            if (accept) begin
                req_pc <= pc_fetch;
            end

            if (!stall_decode) begin
                if (redirect) begin
                    instr_decode    <= '0;
                    pc_plus4_decode <= '0;
                    valid_decode    <= 1'b0;
                    buf_valid       <= 1'b0;
                end else if (buf_valid) begin
                    instr_decode    <= buf_instr;
                    pc_plus4_decode <= buf_pc + INSTR_BYTES;
                    valid_decode    <= 1'b1;
                    buf_valid       <= 1'b0;
                end else if (keep) begin
                    instr_decode    <= imem_rdata;
                    pc_plus4_decode <= req_pc + INSTR_BYTES;
                    valid_decode    <= 1'b1;
                end else begin
                    instr_decode    <= '0;
                    pc_plus4_decode <= '0;
                    valid_decode    <= 1'b0;
                end
            end else if (keep) begin
                buf_valid <= 1'b1;
                buf_instr <= imem_rdata;
                buf_pc    <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table against a zero-wait memory model
// returning address-as-data, plus a reset-during-WAIT sequence with a stale response.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_decode;
    logic [1:0]  pc_source_decode;
    logic        jump_pc_decode;
    logic [31:0] branch_target_decode;
    logic [31:0] jump_target_decode;
    logic [31:0] jr_target_decode;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_decode;
    logic [31:0] pc_plus4_decode;
    logic        valid_decode;
    logic [5:0]  opcode_decode;
    logic [5:0]  funct_decode;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall_decode         (stall_decode),
        .pc_source_decode     (pc_source_decode),
        .jump_pc_decode       (jump_pc_decode),
        .branch_target_decode (branch_target_decode),
        .jump_target_decode   (jump_target_decode),
        .jr_target_decode     (jr_target_decode),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ready           (imem_ready),
        .imem_rvalid          (imem_rvalid),
        .imem_rdata           (imem_rdata),
        .instr_decode         (instr_decode),
        .pc_plus4_decode      (pc_plus4_decode),
        .valid_decode         (valid_decode),
        .opcode_decode        (opcode_decode),
        .funct_decode         (funct_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: answers one cycle after accept with the address as data.
    logic        mem_pend;
    logic [31:0] mem_addr_q;
    logic        stale_inject;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pend   <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            mem_pend <= imem_req & imem_ready;
            if (imem_req & imem_ready) mem_addr_q <= imem_addr;
        end
    end

    assign imem_rvalid = mem_pend | stale_inject;
    assign imem_rdata  = stale_inject ? 32'hDEAD_BEEF : mem_addr_q;

    typedef struct {
        logic        stall;
        logic [1:0]  psrc;
        logic        jpc;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_decode(input string tag, input logic exp_valid, input logic [31:0] exp_instr);
        chk({tag, ".valid"}, 32'(valid_decode), 32'(exp_valid));
        if (exp_valid) begin
            chk({tag, ".instr"}, instr_decode, exp_instr);
            chk({tag, ".pc4"}, pc_plus4_decode, exp_instr + 32'd4);
            chk({tag, ".opcode"}, 32'(opcode_decode), 32'(exp_instr[31:26]));
            chk({tag, ".funct"}, 32'(funct_decode), 32'(exp_instr[5:0]));
        end
    endtask

    initial begin
        reset                = 1'b1;
        stall_decode         = 1'b0;
        pc_source_decode     = 2'b00;
        jump_pc_decode       = 1'b0;
        branch_target_decode = 32'h0040_0100;
        jump_target_decode   = 32'h0040_0300;
        jr_target_decode     = 32'h0040_0200;
        imem_ready           = 1'b1;
        stale_inject         = 1'b0;

        // stall, psrc, jpc, ready | req, addr, valid, instr
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0000, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0004, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0008, 1, 32'h0040_0000});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_000C, 1, 32'h0040_0004});
        vq.push_back('{0, 2'b01, 0, 1, 1, 32'h0040_0010, 1, 32'h0040_0008}); // branch
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0100, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0104, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0108, 1, 32'h0040_0100});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_010C, 1, 32'h0040_0104});
        vq.push_back('{1, 2'b00, 0, 1, 0, 32'h0040_0110, 1, 32'h0040_0108}); // stall x3
        vq.push_back('{1, 2'b00, 0, 1, 0, 32'h0040_0110, 1, 32'h0040_0108});
        vq.push_back('{1, 2'b00, 0, 1, 0, 32'h0040_0110, 1, 32'h0040_0108});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0110, 1, 32'h0040_0108});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0114, 1, 32'h0040_010C});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0118, 1, 32'h0040_0110});
        vq.push_back('{0, 2'b00, 0, 0, 1, 32'h0040_011C, 1, 32'h0040_0114}); // not ready x2
        vq.push_back('{0, 2'b00, 0, 0, 1, 32'h0040_011C, 1, 32'h0040_0118});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_011C, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0120, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0124, 1, 32'h0040_011C});
        vq.push_back('{0, 2'b10, 1, 1, 1, 32'h0040_0128, 1, 32'h0040_0120}); // jr over j
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0200, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0204, 0, 32'h0});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_0208, 1, 32'h0040_0200});
        vq.push_back('{0, 2'b00, 0, 1, 1, 32'h0040_020C, 1, 32'h0040_0204});

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(imem_req), 32'h0);
        chk("rst.addr", imem_addr, 32'h0040_0000);
        chk("rst.valid", 32'(valid_decode), 32'h0);
        chk("rst.instr", instr_decode, 32'h0);
        chk("rst.pc4", pc_plus4_decode, 32'h0);
        reset = 1'b0;

        foreach (vq[i]) begin
            stall_decode     = vq[i].stall;
            pc_source_decode = vq[i].psrc;
            jump_pc_decode   = vq[i].jpc;
            imem_ready       = vq[i].ready;
            #1;
            chk($sformatf("c%0d.req", i), 32'(imem_req), 32'(vq[i].exp_req));
            chk($sformatf("c%0d.addr", i), imem_addr, vq[i].exp_addr);
            chk_decode($sformatf("c%0d", i), vq[i].exp_valid, vq[i].exp_instr);
            @(posedge clk);
            #1;
        end
        stall_decode     = 1'b0;
        pc_source_decode = 2'b00;
        jump_pc_decode   = 1'b0;
        imem_ready       = 1'b1;

        // Reset arrives mid-cycle while a request is outstanding.
        #2;
        reset = 1'b1;
        #1;
        chk("arst.valid", 32'(valid_decode), 32'h0);
        chk("arst.instr", instr_decode, 32'h0);
        chk("arst.pc4", pc_plus4_decode, 32'h0);
        chk("arst.addr", imem_addr, 32'h0040_0000);
        chk("arst.req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        stale_inject = 1'b1;
        #1;
        chk("stale.req", 32'(imem_req), 32'h1);
        chk("stale.addr", imem_addr, 32'h0040_0000);
        chk("stale.valid", 32'(valid_decode), 32'h0);
        @(posedge clk);
        #1;
        stale_inject = 1'b0;
        #1;
        chk("restart1.addr", imem_addr, 32'h0040_0004);
        chk("restart1.valid", 32'(valid_decode), 32'h0);
        @(posedge clk);
        #2;
        chk_decode("restart2", 1'b1, 32'h0040_0000);
        chk("restart2.addr", imem_addr, 32'h0040_0008);
        @(posedge clk);
        #2;
        chk_decode("restart3", 1'b1, 32'h0040_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
